regfile_dump: RTL and testbench

//  Read-side sequencer for the register file. On a start pulse it sweeps a contiguous register range through

---
 rtl/regfile_dump.sv | 148 ++++++++++++++
 tb/tb_regfile_dump.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - register file read-side dump sequencer
//
// Sweeps registers FIRST_REG..LAST_REG through both regfile read ports.
// Each fetch reads two registers. Each register then leaves as one
// {addr,data} beat on a valid/ready stream.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   start                 dump request, sampled only while idle
//   busy, done            busy is high outside IDLE; done is a one-cycle pulse at the end
//   rs1_addr, rs2_addr    regfile read addresses, driven only during FETCH
//   rs1_data, rs2_data    combinational regfile read data
//   out_valid, out_ready  beat handshake
//   out_addr, out_data    register index and contents of the current beat
//   out_last              marks the beat carrying LAST_REG
module regfile_dump #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rs1_addr,
    output logic [ADDR_W-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EMIT0 = 3'd2,
        EMIT1 = 3'd3,
        DONE  = 3'd4
    } state_t;

    // ptr carries one extra bit so ptr+1 cannot wrap when LAST_REG is the top register.
    localparam logic [ADDR_W:0] FIRST = FIRST_REG[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST  = LAST_REG[ADDR_W:0];

    state_t            state, state_nxt;
    logic [ADDR_W:0]   ptr, ptr_nxt;
    logic [ADDR_W:0]   ptr_p1;
    logic [ADDR_W:0]   cur_addr;
    logic [DATA_W-1:0] buf0, buf1;
    logic              load_bufs;

    assign ptr_p1 = ptr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (load_bufs) begin
                buf0 <= rs1_data;
                buf1 <= rs2_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        load_bufs = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ptr_nxt   = FIRST;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                load_bufs = 1'b1;
                state_nxt = EMIT0;
            end
            EMIT0: begin
                if (out_ready) begin
                    state_nxt = (ptr == LAST) ? DONE : EMIT1;
                end
            end
            EMIT1: begin
                if (out_ready) begin
                    if (ptr_p1 == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        ptr_nxt   = ptr + 2'd2;
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // All outputs decode from registered state, ptr and buffers; out_ready feeds only next-state.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        rs1_addr  = '0;
        rs2_addr  = '0;
        out_valid = 1'b0;
        cur_addr  = '0;
        out_data  = '0;
        case (state)
            FETCH: begin
                rs1_addr = ptr[ADDR_W-1:0];
                // The second port idles at 0 when the range ends on the first register of the pair.
                if (ptr_p1 <= LAST) begin
                    rs2_addr = ptr_p1[ADDR_W-1:0];
                end
            end
            EMIT0: begin
                out_valid = 1'b1;
                cur_addr  = ptr;
                out_data  = buf0;
            end
            EMIT1: begin
                out_valid = 1'b1;
                cur_addr  = ptr_p1;
                out_data  = buf1;
            end
            default: begin
            end
        endcase
        out_addr = cur_addr[ADDR_W-1:0];
        out_last = out_valid && (cur_addr == LAST);
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - self-checking bench for regfile_dump
module tb_regfile_dump;

    logic        clk;
    logic        rst;
    logic        start_v   [3];
    logic        ready_v   [3];
    logic        busy_v    [3];
    logic        done_v    [3];
    logic        valid_v   [3];
    logic        last_v    [3];
    logic [4:0]  rs1_a     [3];
    logic [4:0]  rs2_a     [3];
    logic [31:0] rs1_d     [3];
    logic [31:0] rs2_d     [3];
    logic [4:0]  oaddr_v   [3];
    logic [31:0] odata_v   [3];

    int n_cmp;
    int n_fail;

    typedef struct {
        int          sel;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    vec_t tbl[4];

    // Behavioural register files: instance 1 holds DEADBEEF in x4, register 0 always reads 0.
    function automatic logic [31:0] xval(input int sel, input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (sel == 1 && a == 5'd4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + {27'd0, a};
    endfunction

    assign rs1_d[0] = xval(0, rs1_a[0]);
    assign rs2_d[0] = xval(0, rs2_a[0]);
    assign rs1_d[1] = xval(1, rs1_a[1]);
    assign rs2_d[1] = xval(1, rs2_a[1]);
    assign rs1_d[2] = xval(2, rs1_a[2]);
    assign rs2_d[2] = xval(2, rs2_a[2]);

    regfile_dump dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .rs1_addr(rs1_a[0]), .rs2_addr(rs2_a[0]), .rs1_data(rs1_d[0]), .rs2_data(rs2_d[0]),
        .out_valid(valid_v[0]), .out_ready(ready_v[0]), .out_addr(oaddr_v[0]),
        .out_data(odata_v[0]), .out_last(last_v[0])
    );

    regfile_dump #(.FIRST_REG(4), .LAST_REG(4)) dut_one (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .rs1_addr(rs1_a[1]), .rs2_addr(rs2_a[1]), .rs1_data(rs1_d[1]), .rs2_data(rs2_d[1]),
        .out_valid(valid_v[1]), .out_ready(ready_v[1]), .out_addr(oaddr_v[1]),
        .out_data(odata_v[1]), .out_last(last_v[1])
    );

    regfile_dump #(.FIRST_REG(0), .LAST_REG(2)) dut_zero (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .rs1_addr(rs1_a[2]), .rs2_addr(rs2_a[2]), .rs1_data(rs1_d[2]), .rs2_data(rs2_d[2]),
        .out_valid(valid_v[2]), .out_ready(ready_v[2]), .out_addr(oaddr_v[2]),
        .out_data(odata_v[2]), .out_last(last_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full-range dump on the default instance. Called at a negedge while idle
    // (issue_start=1) or already at the FETCH negedge (issue_start=0).
    task automatic run_dump(input bit rand_ready, input bit restart, input bit issue_start);
        beat_t       exp_q[$];
        beat_t       b;
        int          cyc;
        int          beat_idx;
        bit          expect_done;
        bit          finished;
        bit          seen_first;
        bit          prev_stall;
        bit          hold;
        bit          rdy;
        logic [4:0]  prev_addr;
        logic [31:0] prev_data;

        for (int a = 1; a <= 31; a++) begin
            b.addr = a[4:0];
            b.data = 32'h1000_0000 + a;
            b.last = (a == 31);
            exp_q.push_back(b);
        end
        if (issue_start) begin
            start_v[0] = 1'b1;
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        check("fetch_busy", busy_v[0], 1);
        check("fetch_valid", valid_v[0], 0);
        check("fetch_rs1", rs1_a[0], 1);
        check("fetch_rs2", rs2_a[0], 2);

        cyc = 0; beat_idx = 0; expect_done = 0; finished = 0;
        seen_first = 0; prev_stall = 0; hold = 0;
        prev_addr = '0; prev_data = '0;
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            check("done", done_v[0], expect_done);
            if (expect_done) begin
                check("done_busy", busy_v[0], 1);
                finished = 1;
            end else if (valid_v[0]) begin
                if (!seen_first) begin
                    check("first_valid_latency", cyc, 1);
                    seen_first = 1;
                end
                if (prev_stall) begin
                    check("stall_addr", oaddr_v[0], prev_addr);
                    check("stall_data", odata_v[0], prev_data);
                end
                check("emit_rs1_idle", rs1_a[0], 0);
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                    finished = 1;
                end else begin
                    check("beat_addr", oaddr_v[0], exp_q[0].addr);
                    check("beat_data", odata_v[0], exp_q[0].data);
                    check("beat_last", last_v[0], exp_q[0].last);
                    start_v[0] = hold || (restart && (beat_idx == 4 || beat_idx == 19));
                    rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    ready_v[0] = rdy;
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        beat_idx++;
                        prev_stall = 0;
                        if (exp_q.size() == 0) begin
                            expect_done = 1;
                            hold = restart;
                            start_v[0] = restart;
                        end
                    end else begin
                        prev_stall = 1;
                        prev_addr = oaddr_v[0];
                        prev_data = odata_v[0];
                    end
                end
            end else begin
                start_v[0] = hold;
                ready_v[0] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (!finished) check("dump_timeout", 0, 1);
        check("beats_remaining", exp_q.size(), 0);
        check("beat_count", beat_idx, 31);
        @(negedge clk);
        check("idle_busy", busy_v[0], 0);
        check("idle_done", done_v[0], 0);
        if (restart) begin
            @(negedge clk);
            check("restart_fetch_busy", busy_v[0], 1);
            start_v[0] = 1'b0;
        end else begin
            start_v[0] = 1'b0;
        end
        ready_v[0] = 1'b0;
    endtask

    // Short-range instances, checked against the vector table with out_ready held high.
    task automatic run_table(input int sel);
        vec_t q[$];
        int   dcount;
        int   beats;
        foreach (tbl[i]) if (tbl[i].sel == sel) q.push_back(tbl[i]);
        dcount = 0; beats = 0;
        ready_v[sel] = 1'b1;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_v[sel]) dcount++;
            if (valid_v[sel]) begin
                beats++;
                if (q.size() == 0) begin
                    check("tbl_extra_beat", oaddr_v[sel], 5'h1f);
                end else begin
                    check("tbl_addr", oaddr_v[sel], q[0].addr);
                    check("tbl_data", odata_v[sel], q[0].data);
                    check("tbl_last", last_v[sel], q[0].last);
                    void'(q.pop_front());
                end
            end
        end
        check("tbl_remaining", q.size(), 0);
        check("tbl_done_count", dcount, 1);
        check("tbl_busy_end", busy_v[sel], 0);
        ready_v[sel] = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        tbl[0] = '{sel: 1, addr: 5'd4, data: 32'hDEAD_BEEF, last: 1'b1};
        tbl[1] = '{sel: 2, addr: 5'd0, data: 32'h0000_0000, last: 1'b0};
        tbl[2] = '{sel: 2, addr: 5'd1, data: 32'h1000_0001, last: 1'b0};
        tbl[3] = '{sel: 2, addr: 5'd2, data: 32'h1000_0002, last: 1'b1};
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            ready_v[i] = 1'b0;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_v[0], 0);
        check("rst_valid", valid_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_rs1", rs1_a[0], 0);
        check("rst_rs2", rs2_a[0], 0);
        check("rst_addr", oaddr_v[0], 0);
        check("rst_data", odata_v[0], 0);
        check("rst_last", last_v[0], 0);
        rst = 1'b1;
        @(negedge clk);

        run_dump(0, 0, 1);
        run_dump(1, 0, 1);
        run_dump(1, 1, 1);
        run_dump(0, 0, 0);

        run_table(1);
        run_table(2);

        // Stall in EMIT1, then reset asynchronously between clock edges.
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        ready_v[0] = 1'b0;
        @(negedge clk);
        check("pre_rst_emit0_addr", oaddr_v[0], 1);
        ready_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
        check("pre_rst_emit1_addr", oaddr_v[0], 2);
        @(negedge clk);
        check("pre_rst_stall_addr", oaddr_v[0], 2);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", valid_v[0], 0);
        check("async_rst_busy", busy_v[0], 0);
        check("async_rst_rs1", rs1_a[0], 0);
        check("async_rst_rs2", rs2_a[0], 0);
        @(negedge clk);
        check("rst_no_done", done_v[0], 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_done", done_v[0], 0);
        run_dump(0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
